// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-pc selection for sequential, jump, flag branches,
// and call/return through a hardware return-address stack with sticky error flags.
module pc_sequencer #(
    parameter int STACK_DEPTH = 8,
    parameter int ADDR_W      = 12,
    localparam int CNT_W      = $clog2(STACK_DEPTH) + 1,
    localparam int IDX_W      = $clog2(STACK_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [18:0]       instruction,
    input  logic              zero_flag,
    input  logic              carry_flag,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  stack_count,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              push_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic              is_jmp, is_jsb, is_ret, is_brz, is_brc;
    logic [ADDR_W-1:0] pc_inc, target, offset, br_tgt;
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic              unused_instr;

    assign is_jmp = (instruction[18:14] == 5'b11100);
    assign is_jsb = (instruction[18:14] == 5'b11101);
    assign is_ret = (instruction[18:13] == 6'b111100);
    assign is_brz = (instruction[18:16] == 3'b101) && (instruction[15:14] == 2'b00);
    assign is_brc = (instruction[18:16] == 3'b101) && (instruction[15:14] == 2'b10);

    assign pc_inc   = pc_q + 1'b1;
    assign target   = ADDR_W'(instruction[11:0]);
    assign offset   = {{(ADDR_W-8){instruction[7]}}, instruction[7:0]};
    assign br_tgt   = pc_inc + offset;
    assign push_idx = cnt_q[IDX_W-1:0];
    assign pop_idx  = IDX_W'(cnt_q - 1'b1);
    assign unused_instr = instruction[12];

    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        push_d = 1'b0;
        if (!stall) begin
            pc_d = pc_inc;
            if (is_jmp) begin
                pc_d = target;
            end else if (is_jsb) begin
                if (cnt_q < DEPTH_C) begin
                    push_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    pc_d   = target;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (is_ret) begin
                if (cnt_q != '0) begin
                    pc_d  = stack_q[pop_idx];
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    unf_d = 1'b1;
                end
            end else if (is_brz) begin
                if (zero_flag) pc_d = br_tgt;
            end else if (is_brc) begin
                if (carry_flag) pc_d = br_tgt;
            end
        end
    end

    // Stack entries are not reset; only the count defines which are live.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (push_d) stack_q[push_idx] <= pc_inc;
        end
    end

    assign pc              = pc_q;
    assign stack_count     = cnt_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed pc/stack expectations per step.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] instruction;
    logic        zero_flag, carry_flag, stall;
    logic [11:0] pc;
    logic [3:0]  stack_count;
    logic        stack_overflow, stack_underflow;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.STACK_DEPTH(8), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .stall(stall),
        .pc(pc), .stack_count(stack_count),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    localparam logic [18:0] NOP = 19'd0;
    localparam logic [18:0] RET = {6'b111100, 13'd0};

    function automatic logic [18:0] jmp(input logic [11:0] t);
        return {5'b11100, 2'b00, t};
    endfunction
    function automatic logic [18:0] jsb(input logic [11:0] t);
        return {5'b11101, 2'b11, t};
    endfunction
    function automatic logic [18:0] brz(input logic [7:0] off);
        return {3'b101, 2'b00, 6'b111000, off};
    endfunction
    function automatic logic [18:0] brc(input logic [7:0] off);
        return {3'b101, 2'b10, 6'b000000, off};
    endfunction

    // Inputs change 1 time unit after the rising edge, outputs sampled there too.
    task automatic step(input logic [18:0] ins, input logic z, input logic c, input logic st);
        instruction = ins;
        zero_flag   = z;
        carry_flag  = c;
        stall       = st;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        step(NOP, 0, 0, 0);
        step(NOP, 0, 0, 0);
        rst = 1'b0;
        chk("rst_pc", pc, 0);
        chk("rst_cnt", stack_count, 0);
        chk("rst_ovf", stack_overflow, 0);
        chk("rst_unf", stack_underflow, 0);

        for (int i = 1; i <= 5; i++) begin
            step(NOP, 0, 0, 0);
            chk("seq_pc", pc, i);
        end

        rst = 1'b1;
        step(jsb(12'd300), 0, 0, 0);
        rst = 1'b0;
        chk("rst_jsb_pc", pc, 0);
        chk("rst_jsb_cnt", stack_count, 0);

        step(jmp(12'd25), 0, 0, 0);
        chk("jmp_pc", pc, 25);
        step(brz(8'd3), 1, 0, 0);
        chk("brz_taken", pc, 29);
        step(jmp(12'd25), 0, 0, 0);
        step(brz(8'd3), 0, 1, 0);
        chk("brz_not_taken", pc, 26);
        step(jmp(12'd30), 0, 0, 0);
        step(brc(8'd3), 0, 1, 0);
        chk("brc_taken", pc, 34);
        step(brc(8'd3), 1, 0, 0);
        chk("brc_not_taken", pc, 35);
        step({3'b101, 2'b01, 6'd0, 8'd3}, 1, 1, 0);
        chk("br01_seq", pc, 36);

        step(jmp(12'd40), 0, 0, 0);
        step(jsb(12'd45), 0, 0, 0);
        chk("jsb_pc", pc, 45);
        chk("jsb_cnt", stack_count, 1);
        step(RET, 0, 0, 0);
        chk("ret_pc", pc, 41);
        chk("ret_cnt", stack_count, 0);

        // Call chain 100 -> 200 -> ... -> 900, then one call too many.
        step(jmp(12'd100), 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            step(jsb(12'(100 * (k + 1))), 0, 0, 0);
            chk("nest_pc", pc, 100 * (k + 1));
            chk("nest_cnt", stack_count, k);
        end
        chk("nest_ovf_clear", stack_overflow, 0);
        step(jsb(12'd1000), 0, 0, 0);
        chk("ovf_pc", pc, 901);
        chk("ovf_flag", stack_overflow, 1);
        chk("ovf_cnt", stack_count, 8);
        for (int k = 8; k >= 1; k--) begin
            step(RET, 0, 0, 0);
            chk("unwind_pc", pc, 100 * k + 1);
            chk("unwind_cnt", stack_count, k - 1);
        end
        chk("ovf_sticky", stack_overflow, 1);

        step(jmp(12'd7), 0, 0, 0);
        step(RET, 0, 0, 0);
        chk("unf_pc", pc, 8);
        chk("unf_flag", stack_underflow, 1);
        chk("unf_cnt", stack_count, 0);
        step(NOP, 0, 0, 0);
        step(NOP, 0, 0, 0);
        chk("unf_sticky_pc", pc, 10);
        chk("unf_sticky", stack_underflow, 1);

        step(jmp(12'd4095), 0, 0, 0);
        step(NOP, 0, 0, 0);
        chk("wrap_pc", pc, 0);
        step(jmp(12'd2), 0, 0, 0);
        step(brz(8'hFA), 1, 0, 0);
        chk("back_wrap_pc", pc, 4093);

        step(jmp(12'd500), 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(jsb(12'd600), 1, 1, 1);
            chk("stall_pc", pc, 500);
            chk("stall_cnt", stack_count, 0);
        end
        step(jsb(12'd600), 0, 0, 0);
        chk("unstall_pc", pc, 600);
        chk("unstall_cnt", stack_count, 1);
        step(RET, 0, 0, 1);
        chk("stall_ret_pc", pc, 600);
        chk("stall_ret_cnt", stack_count, 1);
        step(RET, 0, 0, 0);
        chk("ret_after_stall", pc, 501);

        rst = 1'b1;
        step(NOP, 0, 0, 0);
        rst = 1'b0;
        chk("final_rst_ovf", stack_overflow, 0);
        chk("final_rst_unf", stack_underflow, 0);
        chk("final_rst_pc", pc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
